// File: rtl/hamming_pkt_encoder_if.sv
// Handshake and framing bundle between the packet source, the SECDED encoder and the decoder.
// The slave modport is the encoder's view; master is the environment driving it.
interface hamming_pkt_encoder_if;
    logic        in_vld;
    logic        in_rdy;
    logic [10:0] in_data;
    logic        in_last;
    logic        wr_sop;
    logic        wr_eop;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        resend_req;
    logic [15:0] inj_mask;
    logic        busy;
    logic        pkt_done;
    logic        retry_fail;

    modport slave (
        input  in_vld, in_data, in_last, resend_req, inj_mask,
        output in_rdy, wr_sop, wr_eop, wr_vld, wr_data, busy, pkt_done, retry_fail
    );

    modport master (
        output in_vld, in_data, in_last, resend_req, inj_mask,
        input  in_rdy, wr_sop, wr_eop, wr_vld, wr_data, busy, pkt_done, retry_fail
    );
endinterface

// File: rtl/hamming_pkt_encoder.sv
// Buffers a packet of 11-bit words, emits extended-Hamming (16,11) codewords with sop/eop
// framing, and replays the packet when the downstream decoder requests a resend.
//
// state | meaning
// LOAD  | accept raw words into the buffer (in_rdy high)
// SOP   | one-cycle start pulse, inj_mask sampled, resend flag cleared
// DATA  | stream len encoded words, first one XORed with inj_mask
// EOP   | one-cycle end pulse
// WAIT  | RESP_WAIT cycles listening for resend_req, then done / replay / drop
module hamming_pkt_encoder #(
    parameter int MAX_WORDS = 64,
    parameter int RESP_WAIT = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hamming_pkt_encoder_if.slave  bus
);
    localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int LW = CW + 1;
    localparam int TW = $clog2(RESP_WAIT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {LOAD, SOP, DATA, EOP, WAIT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]  len_q, len_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           resend_q, resend_d;
    logic           resend_seen;
    logic           wr_en;

    logic           wr_sop_q, wr_sop_d;
    logic           wr_eop_q, wr_eop_d;
    logic           wr_vld_q, wr_vld_d;
    logic [15:0]    wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           pkt_done_q, pkt_done_d;
    logic           retry_fail_q, retry_fail_d;

    logic [10:0]    mem_q [MAX_WORDS];

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c        = '0;
        c[3]     = d[0];
        c[5]     = d[1];
        c[6]     = d[2];
        c[7]     = d[3];
        c[15:9]  = d[10:4];
        c[1]     = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
        c[2]     = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        c[4]     = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[8]     = ^c[15:9];
        c[0]     = ^c[15:1];
        return c;
    endfunction

    assign resend_seen = resend_q | bus.resend_req;

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        len_d        = len_q;
        tmr_d        = tmr_q;
        retry_d      = retry_q;
        resend_d     = resend_q;
        pkt_done_d   = 1'b0;
        retry_fail_d = 1'b0;
        wr_en        = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (bus.in_vld) begin
                    wr_en = 1'b1;
                    // a full buffer ends the packet regardless of in_last
                    if (bus.in_last || (wr_cnt_q == CW'(MAX_WORDS - 1))) begin
                        len_d    = LW'(wr_cnt_q) + LW'(1);
                        wr_cnt_d = '0;
                        state_d  = SOP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end
            SOP: begin
                rd_cnt_d = '0;
                resend_d = 1'b0;
                state_d  = DATA;
            end
            DATA: begin
                resend_d = resend_seen;
                if (LW'(rd_cnt_q) == len_q - LW'(1)) begin
                    state_d = EOP;
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end
            EOP: begin
                resend_d = resend_seen;
                tmr_d    = TW'(RESP_WAIT - 1);
                state_d  = WAIT;
            end
            WAIT: begin
                resend_d = resend_seen;
                if (tmr_q == '0) begin
                    if (!resend_seen) begin
                        pkt_done_d = 1'b1;
                        retry_d    = '0;
                        state_d    = LOAD;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = SOP;
                    end else begin
                        retry_fail_d = 1'b1;
                        retry_d      = '0;
                        state_d      = LOAD;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = LOAD;
        endcase

        // Framing outputs are registered from the next state so they line up with state_q.
        wr_sop_d  = (state_d == SOP);
        wr_eop_d  = (state_d == EOP);
        wr_vld_d  = (state_d == DATA);
        busy_d    = (state_d != LOAD);
        wr_data_d = '0;
        if (wr_vld_d) begin
            wr_data_d = encode(mem_q[rd_cnt_d]);
            if (state_q == SOP) begin
                wr_data_d = wr_data_d ^ bus.inj_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            len_q        <= '0;
            tmr_q        <= '0;
            retry_q      <= '0;
            resend_q     <= 1'b0;
            wr_sop_q     <= 1'b0;
            wr_eop_q     <= 1'b0;
            wr_vld_q     <= 1'b0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            pkt_done_q   <= 1'b0;
            retry_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            len_q        <= len_d;
            tmr_q        <= tmr_d;
            retry_q      <= retry_d;
            resend_q     <= resend_d;
            wr_sop_q     <= wr_sop_d;
            wr_eop_q     <= wr_eop_d;
            wr_vld_q     <= wr_vld_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            pkt_done_q   <= pkt_done_d;
            retry_fail_q <= retry_fail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_cnt_q] <= bus.in_data;
        end
    end

    assign bus.in_rdy     = (state_q == LOAD);
    assign bus.wr_sop     = wr_sop_q;
    assign bus.wr_eop     = wr_eop_q;
    assign bus.wr_vld     = wr_vld_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.retry_fail = retry_fail_q;
endmodule

// File: tb/tb_hamming_pkt_encoder.sv
// Scoreboard bench: driver pushes expected codewords, frame lengths and outcomes;
// a negedge monitor pops and compares whatever the encoder presents.
module tb_hamming_pkt_encoder;
    localparam int MAX_WORDS = 64;
    localparam int RESP_WAIT = 8;
    localparam int MAX_RETRY = 3;
    localparam int LIM       = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_pkt_encoder_if bus();

    hamming_pkt_encoder #(
        .MAX_WORDS(MAX_WORDS), .RESP_WAIT(RESP_WAIT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int passed = 0;

    logic [15:0] exp_q[$];
    int          len_q[$];
    bit          out_q[$];   // 1 = retry_fail expected, 0 = pkt_done expected

    logic [10:0] pw[MAX_WORDS];
    logic [15:0] pmask[MAX_RETRY + 2];
    int          plen;
    int          nres;
    bit          forced;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s", name);
    endtask

    // Extended Hamming: data fills non-power-of-two positions in order; parity p covers positions i with i&p.
    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        logic [15:0] c;
        int k;
        bit x;
        c = '0;
        k = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int i = 1; i < 16; i++) if (((i & p) != 0) && (i != p)) x ^= c[i];
            c[p] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor
    int  cyc = 0;
    int  cnt = 0;
    int  sop_cyc = 0;
    int  eop_cyc = 0;
    bit  in_pkt = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_pkt = 1'b0;
            cnt    = 0;
        end else begin
            if (bus.wr_sop) begin
                if (in_pkt) fail_now("sop_inside_packet");
                in_pkt  = 1'b1;
                cnt     = 0;
                sop_cyc = cyc;
            end
            if (bus.wr_vld) begin
                if (exp_q.size() == 0) fail_now("unexpected_data");
                else check("data", 32'(bus.wr_data), 32'(exp_q.pop_front()));
                cnt++;
            end
            if (bus.wr_eop) begin
                if (len_q.size() == 0) fail_now("unexpected_eop");
                else begin
                    int l;
                    l = len_q.pop_front();
                    check("frame_len", 32'(cnt), 32'(l));
                    check("eop_pos", 32'(cyc - sop_cyc), 32'(l + 1));
                end
                eop_cyc = cyc;
                in_pkt  = 1'b0;
            end
            if (bus.pkt_done || bus.retry_fail) begin
                if (out_q.size() == 0) fail_now("unexpected_outcome");
                else begin
                    bit f;
                    f = out_q.pop_front();
                    check("outcome", 32'({bus.pkt_done, bus.retry_fail}), f ? 32'h1 : 32'h2);
                    check("resp_gap", 32'(cyc - eop_cyc), 32'(RESP_WAIT + 1));
                end
            end
        end
    end

    task automatic push_expect();
        int  ntx;
        bit  fl;
        fl  = (nres > MAX_RETRY);
        ntx = fl ? MAX_RETRY + 1 : nres + 1;
        for (int j = 0; j < ntx; j++) begin
            len_q.push_back(plen);
            for (int i = 0; i < plen; i++)
                exp_q.push_back(ref_enc(pw[i]) ^ ((i == 0) ? pmask[j] : 16'h0));
        end
        out_q.push_back(fl);
    endtask

    task automatic load_pkt();
        int n;
        bus.inj_mask = pmask[0];
        for (int i = 0; i < plen; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = pw[i];
            bus.in_last = !forced && (i == plen - 1);
            n = 0;
            while (!bus.in_rdy && n < LIM) begin
                step();
                n++;
            end
            if (n >= LIM) fail_now("timeout_in_rdy");
            step();
        end
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
        if (forced) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 11'($urandom);
            check("word65_blocked", 32'(bus.in_rdy), 32'h0);
        end
    endtask

    task automatic wait_sop(output bit ok);
        int n;
        n = 0;
        while (!bus.wr_sop && n < LIM) begin
            step();
            n++;
        end
        ok = (n < LIM);
        if (!ok) fail_now("timeout_sop");
    endtask

    task automatic run_pkt();
        int ntx;
        int n;
        int o;
        bit ok;
        ntx = (nres > MAX_RETRY) ? MAX_RETRY + 1 : nres + 1;
        push_expect();
        load_pkt();
        for (int j = 0; j < ntx; j++) begin
            wait_sop(ok);
            if (!ok) return;
            check("busy_in_sop", 32'({bus.busy, bus.in_rdy}), 32'h2);
            step();
            bus.in_vld   = 1'b0;
            bus.inj_mask = pmask[j + 1];
            if (j < nres) begin
                o = $urandom_range(1, plen + 1 + RESP_WAIT);
                repeat (o - 1) step();
                bus.resend_req = 1'b1;
                step();
                bus.resend_req = 1'b0;
            end
        end
        n = 0;
        while (!bus.in_rdy && n < LIM) begin
            step();
            n++;
        end
        if (n >= LIM) fail_now("timeout_return_load");
        step();
    endtask

    task automatic set_pkt(input int l, input int r);
        plen   = l;
        nres   = r;
        forced = 1'b0;
        for (int j = 0; j < MAX_RETRY + 2; j++) pmask[j] = 16'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.in_vld     = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.resend_req = 1'b0;
        bus.inj_mask   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({bus.wr_sop, bus.wr_eop, bus.wr_vld, bus.busy,
                                  bus.pkt_done, bus.retry_fail, bus.wr_data}), 32'h0);
        check("rst_in_rdy", 32'(bus.in_rdy), 32'h1);
        rst_n = 1'b1;
        step();

        // three-word packet, clean delivery
        set_pkt(3, 0);
        pw[0] = 11'h000; pw[1] = 11'h7FF; pw[2] = 11'h001;
        run_pkt();
        // same packet, one resend
        set_pkt(3, 1);
        run_pkt();
        // resend every transmission: retries exhausted
        set_pkt(3, MAX_RETRY + 1);
        run_pkt();
        check("in_rdy_after_fail", 32'(bus.in_rdy), 32'h1);
        // injected error on first word, clean replay
        set_pkt(1, 1);
        pw[0] = 11'h001;
        pmask[0] = 16'h0008;
        run_pkt();
        // forced end at MAX_WORDS
        set_pkt(MAX_WORDS, 0);
        forced = 1'b1;
        for (int i = 0; i < MAX_WORDS; i++) pw[i] = 11'($urandom);
        run_pkt();

        // reset during DATA
        set_pkt(3, 0);
        for (int i = 0; i < 3; i++) pw[i] = 11'($urandom);
        push_expect();
        load_pkt();
        wait_sop(ok);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({bus.wr_sop, bus.wr_eop, bus.wr_vld, bus.busy,
                                     bus.pkt_done, bus.retry_fail, bus.wr_data}), 32'h0);
        check("midrst_in_rdy", 32'(bus.in_rdy), 32'h1);
        exp_q.delete();
        len_q.delete();
        out_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        set_pkt(1, 0);
        pw[0] = 11'h7FF;
        run_pkt();

        // randomized packets
        for (int p = 0; p < 30; p++) begin
            set_pkt(($urandom_range(0, 7) == 0) ? MAX_WORDS : $urandom_range(1, 12),
                    $urandom_range(0, MAX_RETRY + 1));
            forced = (plen == MAX_WORDS) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < plen; i++) pw[i] = 11'($urandom);
            for (int j = 0; j < MAX_RETRY + 1; j++)
                pmask[j] = ($urandom_range(0, 2) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            run_pkt();
        end

        repeat (3) step();
        check("exp_data_drained", 32'(exp_q.size()), 32'h0);
        check("exp_len_drained", 32'(len_q.size()), 32'h0);
        check("exp_outcome_drained", 32'(out_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
